hb_mac_ctrl: RTL and testbench

- Control sequencer for the symmetric halfband decimate-by-2 filter.
- Tracks the circular sample-buffer write pointer and triggers one output computation every second input strobe.
- During a computation it issues one symmetric tap-pair address and coefficient index per clock.
- Produces the pipeline-aligned clear/enable pulses for the downstream accumulator, plus a strobe when the accumulated sum is valid.

---
 rtl/hb_mac_ctrl.sv | 131 +++++++++++++
 tb/tb_hb_mac_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_mac_ctrl.sv
// Control sequencer for a symmetric halfband decimate-by-2 FIR: write pointer, decimation phase,
// tap-pair address issue and pipeline-aligned accumulator clear/enable/valid pulses.
module hb_mac_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int NPAIRS   = 4,
  parameter int PIPE_LAT = 2,
  localparam int CW      = (NPAIRS > 1) ? $clog2(NPAIRS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              strobe_in,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] center_addr,
  output logic [CW-1:0]     coef_addr,
  output logic              acc_clear,
  output logic              acc_enable,
  output logic              strobe_out,
  output logic              busy,
  output logic              overrun
);

  localparam int FW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  localparam logic [ADDR_W-1:0] OFS_B  = ADDR_W'(4 * NPAIRS - 2);
  localparam logic [ADDR_W-1:0] OFS_C  = ADDR_W'(2 * NPAIRS - 1);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [CW-1:0]     K_LAST = CW'(NPAIRS - 1);
  localparam logic [CW-1:0]     ONE_K  = CW'(1);
  localparam logic [FW-1:0]     F_LAST = FW'(PIPE_LAT);
  localparam logic [FW-1:0]     ONE_F  = FW'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state;
  logic              phase;
  logic [CW-1:0]     k;
  logic [FW-1:0]     fcnt;
  // Stage 0 of each pipe is the issue-time flag, aligned with the addresses it belongs to.
  logic [PIPE_LAT:0]   clr_pipe;
  logic [PIPE_LAT:0]   en_pipe;
  logic [PIPE_LAT+1:0] last_pipe;

  logic trigger;
  assign trigger = strobe_in & phase;

  assign acc_clear  = clr_pipe[PIPE_LAT];
  assign acc_enable = en_pipe[PIPE_LAT];
  assign strobe_out = last_pipe[PIPE_LAT+1];

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state       <= IDLE;
      phase       <= 1'b0;
      k           <= '0;
      fcnt        <= '0;
      wr_addr     <= '0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      center_addr <= '0;
      coef_addr   <= '0;
      busy        <= 1'b0;
      clr_pipe    <= '0;
      en_pipe     <= '0;
      last_pipe   <= '0;
      if (reset) overrun <= 1'b0;
    end else begin
      for (int i = PIPE_LAT; i > 0; i--) begin
        clr_pipe[i] <= clr_pipe[i-1];
        en_pipe[i]  <= en_pipe[i-1];
      end
      for (int i = PIPE_LAT + 1; i > 0; i--) begin
        last_pipe[i] <= last_pipe[i-1];
      end
      clr_pipe[0]  <= 1'b0;
      en_pipe[0]   <= 1'b0;
      last_pipe[0] <= 1'b0;

      if (strobe_in) begin
        wr_addr <= wr_addr + ONE_A;
        phase   <= ~phase;
      end

      case (state)
        IDLE: begin
          if (trigger) begin
            // The sample being written this cycle is the newest tap of the run.
            state        <= RUN;
            busy         <= 1'b1;
            k            <= '0;
            rd_addr_a    <= wr_addr;
            rd_addr_b    <= wr_addr - OFS_B;
            center_addr  <= wr_addr - OFS_C;
            coef_addr    <= '0;
            clr_pipe[0]  <= 1'b1;
            en_pipe[0]   <= 1'b1;
            last_pipe[0] <= (K_LAST == '0);
          end
        end
        RUN: begin
          if (k == K_LAST) begin
            state <= FLUSH;
            fcnt  <= '0;
          end else begin
            k            <= k + ONE_K;
            rd_addr_a    <= rd_addr_a - STEP;
            rd_addr_b    <= rd_addr_b + STEP;
            coef_addr    <= coef_addr + ONE_K;
            en_pipe[0]   <= 1'b1;
            last_pipe[0] <= ((k + ONE_K) == K_LAST);
          end
        end
        FLUSH: begin
          if (fcnt == F_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            fcnt <= fcnt + ONE_F;
          end
        end
        default: state <= IDLE;
      endcase

      if (trigger && (state != IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hb_mac_ctrl.sv
// Scoreboard bench for hb_mac_ctrl: stimulus pushes expected runs/strobes, monitors pop and compare.
module tb_hb_mac_ctrl;
  localparam int AW = 5;
  localparam int NP = 4;
  localparam int PL = 2;
  localparam int TRIG_TO_STB = 7;  // NPAIRS + PIPE_LAT + 1

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic strobe_in = 1'b0;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b, center_addr;
  logic [1:0] coef_addr;
  logic acc_clear, acc_enable, strobe_out, busy, overrun;

  hb_mac_ctrl #(.ADDR_W(AW), .NPAIRS(NP), .PIPE_LAT(PL)) dut (
    .clock(clock), .reset(reset), .enable(enable), .strobe_in(strobe_in),
    .wr_addr(wr_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .center_addr(center_addr), .coef_addr(coef_addr),
    .acc_clear(acc_clear), .acc_enable(acc_enable), .strobe_out(strobe_out),
    .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    int                   trig;
    int                   nk;
    logic [3:0][AW-1:0]   a;
    logic [3:0][AW-1:0]   b;
    logic [AW-1:0]        c;
  } run_t;

  run_t run_q[$];
  int   stb_q[$];
  int   tests = 0;
  int   fails = 0;

  int   m_phase, m_wr, m_busy_end;
  bit   m_ovr;
  bit   hand_vld;
  run_t hand;
  bit   mon_prev;
  int   en_cnt;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic model_clear(input bit hard);
    m_phase = 0;
    m_wr = 0;
    m_busy_end = -100;
    if (hard) m_ovr = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    model_clear(1'b1);
  endtask

  // One strobe this cycle; nk < NP marks a run that will be cut short by the caller.
  task automatic strobe(input int nk);
    run_t r;
    strobe_in = 1'b1;
    if (m_phase == 1) begin
      if (cyc > m_busy_end) begin
        r.trig = cyc;
        r.nk = nk;
        if (hand_vld) begin
          r.a = hand.a;
          r.b = hand.b;
          r.c = hand.c;
          hand_vld = 1'b0;
        end else begin
          for (int k = 0; k < NP; k++) begin
            r.a[k] = AW'(m_wr - 2 * k);
            r.b[k] = AW'(m_wr - (4 * NP - 2) + 2 * k);
          end
          r.c = AW'(m_wr - (2 * NP - 1));
        end
        run_q.push_back(r);
        if (nk == NP) stb_q.push_back(cyc + TRIG_TO_STB);
        m_busy_end = cyc + TRIG_TO_STB;
      end else begin
        m_ovr = 1'b1;
      end
    end
    m_phase ^= 1;
    m_wr = (m_wr + 1) % 32;
    tick();
    strobe_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_addr_a"}, rd_addr_a, 0);
    chk({tag, "_rd_addr_b"}, rd_addr_b, 0);
    chk({tag, "_center_addr"}, center_addr, 0);
    chk({tag, "_coef_addr"}, coef_addr, 0);
    chk({tag, "_acc_clear"}, acc_clear, 0);
    chk({tag, "_acc_enable"}, acc_enable, 0);
    chk({tag, "_strobe_out"}, strobe_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // Address-issue monitor: a rising busy opens a run, checked tap pair by tap pair.
  initial begin
    run_t r;
    mon_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && enable && busy && !mon_prev) begin
        if (run_q.size() == 0) begin
          chk("unexpected_run", 1, 0);
        end else begin
          r = run_q.pop_front();
          chk("run_start", cyc, r.trig + 1);
          for (int k = 0; k < r.nk; k++) begin
            if (k > 0) @(negedge clock);
            chk("rd_addr_a", rd_addr_a, r.a[k]);
            chk("rd_addr_b", rd_addr_b, r.b[k]);
            chk("coef_addr", coef_addr, k);
            chk("center_addr", center_addr, r.c);
            chk("a_ne_b", (rd_addr_a != rd_addr_b) ? 1 : 0, 1);
          end
        end
      end
      mon_prev = busy;
    end
  end

  // Accumulator-control monitor: counts enables per run and checks each sum-valid pulse.
  initial begin
    en_cnt = 0;
    forever begin
      @(negedge clock);
      if (acc_clear) begin
        chk("clear_with_enable", acc_enable, 1);
        en_cnt = 0;
      end
      if (acc_enable) en_cnt++;
      if (strobe_out) begin
        if (stb_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          chk("strobe_cycle", cyc, stb_q.pop_front());
          chk("enables_per_run", en_cnt, NP);
          chk("busy_at_strobe", busy, 1);
        end
        en_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    model_clear(1'b1);
    hand_vld = 1'b0;

    // Basic run: strobes at 10 and 20, trigger with base 1.
    do_reset(3);
    c0 = cyc;
    check_zero("reset");
    wait_to(c0 + 10);
    strobe(NP);
    wait_to(c0 + 20);
    hand.a[0] = 5'd1;  hand.a[1] = 5'd31; hand.a[2] = 5'd29; hand.a[3] = 5'd27;
    hand.b[0] = 5'd19; hand.b[1] = 5'd21; hand.b[2] = 5'd23; hand.b[3] = 5'd25;
    hand.c = 5'd26;
    hand_vld = 1'b1;
    chk("wr_addr_at_trigger", wr_addr, 1);
    strobe(NP);
    wait_to(c0 + 27);
    chk("busy_last_cycle", busy, 1);
    tick();
    chk("busy_low_after_run", busy, 0);
    chk("wr_addr_after_basic", wr_addr, 2);

    // Decimation: 8 strobes, 10 cycles apart.
    for (int i = 0; i < 8; i++) begin
      strobe(NP);
      repeat (9) tick();
    end
    chk("overrun_decim", overrun, 0);

    // Wrap: 42 strobes carry the pointer past 32.
    do_reset(2);
    for (int i = 0; i < 42; i++) begin
      strobe(NP);
      repeat (9) tick();
    end
    chk("wr_addr_wrapped", wr_addr, 10);
    chk("overrun_wrap", overrun, 0);

    // Abort: reset in cycle 22 of a run.
    do_reset(2);
    c0 = cyc;
    wait_to(c0 + 10);
    strobe(NP);
    wait_to(c0 + 20);
    strobe(1);
    wait_to(c0 + 22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear(1'b1);
    check_zero("abort");
    repeat (5) tick();
    strobe(NP);
    chk("no_trigger_after_abort", busy, 0);
    chk("wr_addr_after_abort", wr_addr, 1);

    // Overrun: strobes every 2 cycles.
    for (int i = 0; i < 12; i++) begin
      strobe(NP);
      tick();
    end
    chk("overrun_set", overrun, 1);
    chk("overrun_model", overrun, m_ovr);
    repeat (20) tick();
    chk("overrun_sticky", overrun, 1);

    // enable low for one cycle, two cycles into a run.
    if (m_phase == 0) begin
      strobe(NP);
      repeat (3) tick();
    end
    strobe(2);
    tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    model_clear(1'b0);
    chk("en_low_wr_addr", wr_addr, 0);
    chk("en_low_overrun", overrun, 1);
    chk("en_low_busy", busy, 0);
    chk("en_low_acc_clear", acc_clear, 0);
    chk("en_low_acc_enable", acc_enable, 0);
    chk("en_low_strobe_out", strobe_out, 0);

    // Recovery run after the soft clear.
    repeat (5) tick();
    strobe(NP);
    repeat (9) tick();
    strobe(NP);
    repeat (15) tick();
    chk("runs_pending", run_q.size(), 0);
    chk("strobes_pending", stb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
